// File: rtl/mmss_countdown.sv
// mmss_countdown: BCD minutes:seconds countdown timer.
// Counts down one second per prescaler tick, pulses done at 00:00 and holds
// an alarm level for ALARM_LEN ticks afterwards.
// Optional build macro AUTO_RELOAD_EN: on expiry the count reloads from the
// value captured by the last accepted load and keeps running (no alarm).
module mmss_countdown #(
  parameter int ALARM_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [7:0] LP_ALARM_LEN = 8'(ALARM_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_ALARM  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] w_min_next;
  logic [7:0] w_sec_next;
  logic [7:0] r_alarm_cnt;
  logic [7:0] w_alarm_cnt_next;
  logic       r_running;
  logic       r_done;
  logic       r_alarm;
  logic       r_load_err;
  logic       w_done_next;
  logic       w_load_err_next;

`ifdef AUTO_RELOAD_EN
  logic [7:0] r_shad_min;
  logic [7:0] r_shad_sec;
  logic [7:0] w_shad_min_next;
  logic [7:0] w_shad_sec_next;
  logic       w_shad_nz;

  // A never-loaded (00:00) shadow means "no reload target"
  assign w_shad_nz = (r_shad_min != 8'h00) || (r_shad_sec != 8'h00);
`endif

  // Digit order: 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens.
  logic [3:0] w_dig     [4];
  logic [3:0] w_dig_dec [4];
  logic [3:0] w_borrow;
  logic [3:0] w_ld_dig  [4];
  logic [3:0] w_ld_ok;
  logic       w_load_ok;
  logic       w_is_zero;
  logic       w_is_one;

  assign w_dig[0]    = r_sec[3:0];
  assign w_dig[1]    = r_sec[7:4];
  assign w_dig[2]    = r_min[3:0];
  assign w_dig[3]    = r_min[7:4];
  assign w_ld_dig[0] = load_sec[3:0];
  assign w_ld_dig[1] = load_sec[7:4];
  assign w_ld_dig[2] = load_min[3:0];
  assign w_ld_dig[3] = load_min[7:4];

  // The decrement request enters at sec units and ripples as a borrow.
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      // Sec tens wraps 0 -> 5; every other digit wraps 0 -> 9. Min tens never
      // wraps in practice because RUN is never entered at 00:00.
      localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;

      assign w_dig_dec[gi] = !w_borrow[gi]        ? w_dig[gi] :
                             (w_dig[gi] == 4'd0)  ? LIM       :
                                                    w_dig[gi] - 4'd1;

      assign w_ld_ok[gi] = (w_ld_dig[gi] <= LIM);

      if (gi < 3) begin : g_borrow
        assign w_borrow[gi+1] = w_borrow[gi] && (w_dig[gi] == 4'd0);
      end
    end
  endgenerate

  assign w_load_ok = &w_ld_ok;
  assign w_is_zero = (r_min == 8'h00) && (r_sec == 8'h00);
  assign w_is_one  = (r_min == 8'h00) && (r_sec == 8'h01);

  // Next-state and next-value decode; priority load > pause > start > tick
  always_comb begin
    w_state_next     = r_state;
    w_min_next       = r_min;
    w_sec_next       = r_sec;
    w_alarm_cnt_next = r_alarm_cnt;
    w_done_next      = 1'b0;
    w_load_err_next  = 1'b0;
`ifdef AUTO_RELOAD_EN
    w_shad_min_next  = r_shad_min;
    w_shad_sec_next  = r_shad_sec;
`endif

    case (r_state)
      S_IDLE, S_PAUSED: begin
        if (load) begin
          if (w_load_ok) begin
            w_min_next = load_min;
            w_sec_next = load_sec;
`ifdef AUTO_RELOAD_EN
            w_shad_min_next = load_min;
            w_shad_sec_next = load_sec;
`endif
          end else begin
            w_load_err_next = 1'b1;
          end
        end else if (start && !w_is_zero) begin
          w_state_next = S_RUN;
        end
      end

      S_RUN: begin
        // Loads are not accepted while counting, so they fall through here.
        if (pause) begin
          w_state_next = S_PAUSED;
        end else if (tick) begin
          if (w_is_one) begin
            w_done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
            if (w_shad_nz) begin
              w_min_next = r_shad_min;
              w_sec_next = r_shad_sec;
            end else begin
              w_min_next       = 8'h00;
              w_sec_next       = 8'h00;
              w_alarm_cnt_next = 8'd0;
              w_state_next     = S_ALARM;
            end
`else
            w_min_next       = 8'h00;
            w_sec_next       = 8'h00;
            w_alarm_cnt_next = 8'd0;
            w_state_next     = S_ALARM;
`endif
          end else begin
            w_min_next = {w_dig_dec[3], w_dig_dec[2]};
            w_sec_next = {w_dig_dec[1], w_dig_dec[0]};
          end
        end
      end

      S_ALARM: begin
        if (load) begin
          if (w_load_ok) begin
            w_min_next   = load_min;
            w_sec_next   = load_sec;
            w_state_next = S_IDLE;
`ifdef AUTO_RELOAD_EN
            w_shad_min_next = load_min;
            w_shad_sec_next = load_sec;
`endif
          end else begin
            w_load_err_next = 1'b1;
          end
        end else if (start) begin
          // Start acts as an alarm acknowledge.
          w_state_next = S_IDLE;
        end else if (tick) begin
          w_alarm_cnt_next = r_alarm_cnt + 8'd1;
          if ((r_alarm_cnt + 8'd1) == LP_ALARM_LEN) begin
            w_state_next = S_IDLE;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_min       <= 8'h00;
      r_sec       <= 8'h00;
      r_alarm_cnt <= 8'd0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_min       <= w_min_next;
      r_sec       <= w_sec_next;
      r_alarm_cnt <= w_alarm_cnt_next;
      r_running   <= (w_state_next == S_RUN);
      r_done      <= w_done_next;
      r_alarm     <= (w_state_next == S_ALARM);
      r_load_err  <= w_load_err_next;
    end
  end

`ifdef AUTO_RELOAD_EN
  // Reload shadow, captured on every accepted load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shad_min <= 8'h00;
      r_shad_sec <= 8'h00;
    end else begin
      r_shad_min <= w_shad_min_next;
      r_shad_sec <= w_shad_sec_next;
    end
  end
`endif

  assign min_o    = r_min;
  assign sec_o    = r_sec;
  assign running  = r_running;
  assign done     = r_done;
  assign alarm    = r_alarm;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_mmss_countdown.sv
// Testbench for mmss_countdown: directed scenarios followed by random
// stimulus, all checked against a seconds-based behavioural model.
// Honours AUTO_RELOAD_EN when the design is built with it.
module tb_mmss_countdown;

  localparam int ALARM_LEN = 5;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_ALARM   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  mmss_countdown #(.ALARM_LEN(ALARM_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .min_o    (min_o),
    .sec_o    (sec_o),
    .running  (running),
    .done     (done),
    .alarm    (alarm),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_miscmp = 0;

  // Reference model: the count is kept as plain total seconds.
  int   m_state;
  int   m_val;
  int   m_shadow;
  int   m_cnt;
  logic e_done;
  logic e_err;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Packed view: {min, sec, running, done, alarm, load_err}
  function automatic logic [19:0] expected();
    return {to_bcd(m_val / 60), to_bcd(m_val % 60),
            (m_state == M_RUN), e_done, (m_state == M_ALARM), e_err};
  endfunction

  function automatic logic [19:0] observed();
    return {min_o, sec_o, running, done, alarm, load_err};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_val    = 0;
    m_shadow = 0;
    m_cnt    = 0;
    e_done   = 1'b0;
    e_err    = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                            input logic st, input logic ps, input logic tk);
    logic [7:0] lmv;
    logic [7:0] lsv;
    bit         valid;
    int         v;
    lmv    = lm;
    lsv    = ls;
    e_done = 1'b0;
    e_err  = 1'b0;
    valid  = (lmv[7:4] <= 4'd9) && (lmv[3:0] <= 4'd9) &&
             (lsv[7:4] <= 4'd5) && (lsv[3:0] <= 4'd9);
    v = (int'(lmv[7:4]) * 10 + int'(lmv[3:0])) * 60 + int'(lsv[7:4]) * 10 + int'(lsv[3:0]);
    if (ld && m_state != M_RUN) begin
      if (valid) begin
        m_val    = v;
        m_shadow = v;
        if (m_state == M_ALARM) m_state = M_IDLE;
      end else begin
        e_err = 1'b1;
      end
    end else if (ps && m_state == M_RUN) begin
      m_state = M_PAUSED;
    end else if (st && (m_state == M_IDLE || m_state == M_PAUSED)) begin
      if (m_val != 0) m_state = M_RUN;
    end else if (st && m_state == M_ALARM) begin
      m_state = M_IDLE;
    end else if (tk && m_state == M_RUN) begin
      if (m_val == 1) begin
        e_done = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (m_shadow != 0) begin
          m_val = m_shadow;
        end else begin
          m_val   = 0;
          m_state = M_ALARM;
          m_cnt   = 0;
        end
`else
        m_val   = 0;
        m_state = M_ALARM;
        m_cnt   = 0;
`endif
      end else begin
        m_val = m_val - 1;
      end
    end else if (tk && m_state == M_ALARM) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == ALARM_LEN) m_state = M_IDLE;
    end
  endtask

  // One clock of stimulus, then compare the DUT with the model.
  task automatic step(input string tag, input logic a_ld, input logic [7:0] a_lm,
                      input logic [7:0] a_ls, input logic a_st, input logic a_ps,
                      input logic a_tk);
    @(negedge clk);
    load     = a_ld;
    load_min = a_lm;
    load_sec = a_ls;
    start    = a_st;
    pause    = a_ps;
    tick     = a_tk;
    @(posedge clk);
    model_step(a_ld, a_lm, a_ls, a_st, a_ps, a_tk);
    #1;
    check(tag, observed(), expected());
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      step(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reset raised between edges must clear everything without waiting for clk.
  task automatic areset();
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    tick  = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", observed(), 20'h00000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tick     = 1'b0;
    load     = 1'b0;
    load_min = 8'h00;
    load_sec = 8'h00;
    start    = 1'b0;
    pause    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", observed(), 20'h00000);
    @(negedge clk);
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Borrow chain from 10:00
    step("ld_1000", 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    step("start",   1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks("tick", 1);
    check("borrow_0959", observed(), 20'h09598);
    ticks("tick", 59);
    check("borrow_0900", observed(), 20'h09008);
    ticks("tick", 1);
    check("borrow_0859", observed(), 20'h08598);

    // Reset in the middle of a count
    step("pause",   1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step("ld_0130", 1'b1, 8'h01, 8'h30, 1'b0, 1'b0, 1'b0);
    step("start",   1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks("tick", 5);
    check("count_0125", observed(), 20'h01258);
    areset();

`ifndef AUTO_RELOAD_EN
    // Expiry and alarm duration
    step("ld_0002", 1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    step("start",   1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks("tick", 1);
    step("tick_exp", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("expire", observed(), 20'h00006);
    step("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("done_1clk", observed(), 20'h00002);
    ticks("alarm_tick", ALARM_LEN - 1);
    check("alarm_held", observed(), 20'h00002);
    step("alarm_end", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("alarm_off", observed(), 20'h00000);
`else
    // Auto reload keeps counting from the loaded value
    step("ld_0003", 1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    step("start",   1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks("tick", 2);
    step("tick_exp", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("reload1", observed(), 20'h0003C);
    step("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    ticks("tick", 2);
    step("tick_exp", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("reload2", observed(), 20'h0003C);
    step("pause", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

    // Pause/start and priorities
    step("ld_0010", 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
    step("start",   1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks("tick", 3);
    step("pause_tick", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check("pause_hold", observed(), 20'h00070);
    ticks("paused_tick", 10);
    check("paused_hold", observed(), 20'h00070);
    step("resume", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step("tick",   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("resume_0006", observed(), 20'h00068);
    step("ld_in_run", 1'b1, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0);
    check("ld_run_ignored", observed(), 20'h00068);

    // Invalid loads and start at zero
    step("pause", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step("ld_bad_sec", 1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0);
    check("bad_sec", observed(), 20'h00061);
    step("ld_bad_min", 1'b1, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0);
    check("bad_min", observed(), 20'h00061);
    step("ld_0000", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step("start_zero", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("zero_start", observed(), 20'h00000);

    // Random traffic, biased toward short counts so expiry happens often
    for (int i = 0; i < 3000; i++) begin
      logic       r_ld;
      logic [7:0] r_lm;
      logic [7:0] r_ls;
      logic       r_st;
      logic       r_ps;
      logic       r_tk;
      r_ld = ($urandom % 30) == 0;
      r_lm = (($urandom % 8) == 0) ? 8'($urandom) : {4'h0, 4'($urandom % 2)};
      r_ls = (($urandom % 8) == 0) ? 8'($urandom) : {4'($urandom % 2), 4'($urandom % 10)};
      r_st = ($urandom % 8) == 0;
      r_ps = ($urandom % 25) == 0;
      r_tk = ($urandom % 2) == 0;
      if (($urandom % 1000) == 0) begin
        areset();
      end else begin
        step("rand", r_ld, r_lm, r_ls, r_st, r_ps, r_tk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
